// File: rtl/sm3_pad_pkg.sv
// Shared types and helpers for the SM3 message padder.
// Holds the FSM states, block geometry and the byte-mask/0x80 insertion function.
package sm3_pad_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PAD, LEN} state_t;

  localparam int BLK_BITS = 512;
  localparam int LEN_BITS = 64;

  function automatic int calc_wpb(input int dw);
    return BLK_BITS / dw;
  endfunction

  function automatic int calc_lww(input int dw);
    return LEN_BITS / dw;
  endfunction

  // Keeps the first k bytes (MSB first) of an nb-byte word, puts 0x80 in byte k, zeros below.
  function automatic logic [63:0] ins80_mask(input logic [63:0] d, input int nb, input int k);
    logic [63:0] r;
    int sh;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < nb) begin
        sh = 8 * (nb - 1 - i);
        if (i < k) r |= d & (64'hFF << sh);
        else if (i == k) r |= 64'h80 << sh;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sm3_pad_byte_ins.sv
// Masks a final message word to its k valid bytes and appends the 0x80 marker.
// With k equal to the full byte count the word passes through unchanged.
module sm3_pad_byte_ins
  import sm3_pad_pkg::*;
#(
  parameter int DW = 32,
  parameter int KW = 3
) (
  input  logic [DW-1:0] d,
  input  logic [KW-1:0] k,
  output logic [DW-1:0] q
);

  assign q = DW'(ins80_mask(64'(d), DW / 8, int'(k)));

endmodule

// File: rtl/sm3_pad_p.sv
// Parametrised SM3 padder: message words, 0x80, zero fill, 64-bit bit length,
// emitted as 512-bit blocks serialised into DW-bit words with a stall enable.
module sm3_pad_p
  import sm3_pad_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 61
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   msg_inpt_d,
  input  logic [DW/8-1:0] msg_inpt_vld_byte,
  input  logic            msg_inpt_vld,
  input  logic            msg_inpt_lst,
  output logic            msg_inpt_rdy,
  input  logic            pad_otpt_ena,
  output logic [DW-1:0]   pad_otpt_d,
  output logic            pad_otpt_vld,
  output logic            pad_otpt_lst,
  output logic            pad_otpt_blk_lst
);

  localparam int WPB = calc_wpb(DW);
  localparam int LWW = calc_lww(DW);
  localparam int NB  = DW / 8;
  localparam int KW  = $clog2(NB + 1);
  localparam int WIW = $clog2(WPB);
  localparam logic [WIW-1:0] LEN_START = WIW'(WPB - LWW);
  localparam logic [WIW-1:0] WIDX_LAST = WIW'(WPB - 1);
  localparam logic [DW-1:0]  PAD80_WORD = {8'h80, {(DW-8){1'b0}}};

  state_t            state, state_n;
  logic [WIW-1:0]    widx, widx_n, widx_inc;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              ins80, ins80_n;
  logic [DW-1:0]     d_n;
  logic              vld_n, lst_n, blk_n;
  logic [KW-1:0]     k;
  logic [DW-1:0]     ins_word;
  logic [CNT_W+2:0]  bit_len;
  logic [63:0]       len64;
  logic [DW-1:0]     len_word;
  int                lidx;
  logic              xfer;

  assign msg_inpt_rdy = pad_otpt_ena && !rst && (state == IDLE || state == DATA);
  assign xfer         = msg_inpt_vld && msg_inpt_rdy;
  assign widx_inc     = widx + WIW'(1);
  assign bit_len      = {cnt, 3'b000};
  assign len64        = 64'(bit_len);

  always_comb begin
    k = '0;
    for (int i = 0; i < NB; i++) k = k + KW'(msg_inpt_vld_byte[i]);
  end

  sm3_pad_byte_ins #(.DW(DW), .KW(KW)) u_byte_ins (
    .d (msg_inpt_d),
    .k (k),
    .q (ins_word)
  );

  // Length words go out most significant first, indexed from the start of the length field.
  always_comb begin
    lidx = 0;
    if (state == LEN) lidx = int'(widx) - (WPB - LWW);
    len_word = DW'(len64 >> (DW * (LWW - 1 - lidx)));
  end

  always_comb begin
    state_n = state;
    widx_n  = widx;
    cnt_n   = cnt;
    ins80_n = ins80;
    d_n     = '0;
    vld_n   = 1'b0;
    lst_n   = 1'b0;
    blk_n   = 1'b0;
    case (state)
      IDLE, DATA: begin
        if (xfer) begin
          d_n    = msg_inpt_lst ? ins_word : msg_inpt_d;
          vld_n  = 1'b1;
          blk_n  = (widx == WIDX_LAST);
          widx_n = widx_inc;
          cnt_n  = cnt + CNT_W'(k);
          if (msg_inpt_lst) begin
            ins80_n = (k == KW'(NB));
            // Skip PAD entirely when nothing remains to fill, so no bubble appears.
            state_n = ((k == KW'(NB)) || (widx_inc != LEN_START)) ? PAD : LEN;
          end else begin
            state_n = DATA;
          end
        end
      end
      PAD: begin
        d_n     = ins80 ? PAD80_WORD : '0;
        vld_n   = 1'b1;
        blk_n   = (widx == WIDX_LAST);
        widx_n  = widx_inc;
        ins80_n = 1'b0;
        if (widx_inc == LEN_START) state_n = LEN;
      end
      LEN: begin
        d_n    = len_word;
        vld_n  = 1'b1;
        blk_n  = (widx == WIDX_LAST);
        widx_n = widx_inc;
        if (widx == WIDX_LAST) begin
          lst_n   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
          ins80_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      widx             <= '0;
      cnt              <= '0;
      ins80            <= 1'b0;
      pad_otpt_d       <= '0;
      pad_otpt_vld     <= 1'b0;
      pad_otpt_lst     <= 1'b0;
      pad_otpt_blk_lst <= 1'b0;
    end else if (pad_otpt_ena) begin
      state            <= state_n;
      widx             <= widx_n;
      cnt              <= cnt_n;
      ins80            <= ins80_n;
      pad_otpt_d       <= d_n;
      pad_otpt_vld     <= vld_n;
      pad_otpt_lst     <= lst_n;
      pad_otpt_blk_lst <= blk_n;
    end
  end

endmodule

// File: tb/tb_sm3_pad_p.sv
// Scoreboard bench for sm3_pad_p at DW=32 and DW=64, plus the byte-insert helper.
// A reference padder builds expected words; a monitor collects words the DUT emits.
module tb_sm3_pad_p;

  typedef struct packed {
    logic [63:0] d;
    logic        lst;
    logic        blk;
  } word_t;

  logic        clk, rst, ena;
  logic [31:0] d32, od32;
  logic [3:0]  vb32;
  logic        vld32, lst32, rdy32, ovld32, olst32, oblk32;
  logic [63:0] d64, od64;
  logic [7:0]  vb64;
  logic        vld64, lst64, rdy64, ovld64, olst64, oblk64;
  logic [31:0] ins_d, ins_q;
  logic [2:0]  ins_k;

  word_t        exp_q[$], obs32[$], obs64[$], run_words[$];
  byte unsigned msg_q[$];
  int           cmp = 0;
  int           fails = 0;

  sm3_pad_p #(.DW(32), .CNT_W(61)) dut32 (
    .clk(clk), .rst(rst), .msg_inpt_d(d32), .msg_inpt_vld_byte(vb32),
    .msg_inpt_vld(vld32), .msg_inpt_lst(lst32), .msg_inpt_rdy(rdy32),
    .pad_otpt_ena(ena), .pad_otpt_d(od32), .pad_otpt_vld(ovld32),
    .pad_otpt_lst(olst32), .pad_otpt_blk_lst(oblk32)
  );

  sm3_pad_p #(.DW(64), .CNT_W(61)) dut64 (
    .clk(clk), .rst(rst), .msg_inpt_d(d64), .msg_inpt_vld_byte(vb64),
    .msg_inpt_vld(vld64), .msg_inpt_lst(lst64), .msg_inpt_rdy(rdy64),
    .pad_otpt_ena(ena), .pad_otpt_d(od64), .pad_otpt_vld(ovld64),
    .pad_otpt_lst(olst64), .pad_otpt_blk_lst(oblk64)
  );

  sm3_pad_byte_ins #(.DW(32), .KW(3)) u_ins (.d(ins_d), .k(ins_k), .q(ins_q));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  // Words count as delivered when valid with the enable high at the following edge.
  always begin
    word_t w;
    @(negedge clk);
    #2;
    if (!rst && ena) begin
      if (ovld32) begin
        w.d = 64'(od32); w.lst = olst32; w.blk = oblk32;
        obs32.push_back(w);
      end
      if (ovld64) begin
        w.d = od64; w.lst = olst64; w.blk = oblk64;
        obs64.push_back(w);
      end
    end
  end

  task automatic load_msg(input int n, input bit abc);
    msg_q.delete();
    if (abc) begin
      msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    end else begin
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic build_exp(input int dw);
    byte unsigned    p[$];
    longint unsigned bl;
    word_t           w;
    int              nb, wpb, nw;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = longint'(msg_q.size()) * 8;
    for (int i = 7; i >= 0; i--) p.push_back(8'(bl >> (8 * i)));
    nb = dw / 8; wpb = 64 / nb; nw = p.size() / nb;
    for (int i = 0; i < nw; i++) begin
      w.d = '0;
      for (int j = 0; j < nb; j++) w.d = (w.d << 8) | 64'(p[i*nb+j]);
      w.lst = (i == nw - 1);
      w.blk = (i % wpb == wpb - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic send_msg(input int dw, input int abort_after);
    int          nb, beats, guard;
    bit          took, timed_out;
    logic [63:0] w;
    logic [7:0]  vb;
    nb = dw / 8;
    beats = (msg_q.size() == 0) ? 1 : (msg_q.size() + nb - 1) / nb;
    timed_out = 1'b0;
    for (int b = 0; b < beats; b++) begin
      if (b == abort_after || timed_out) break;
      w = '0; vb = '0;
      for (int j = 0; j < nb; j++) begin
        if (b * nb + j < msg_q.size()) begin
          w  |= 64'(msg_q[b*nb+j]) << (8 * (nb - 1 - j));
          vb |= 8'(1) << (nb - 1 - j);
        end
      end
      @(negedge clk);
      if (dw == 32) begin
        d32 = w[31:0]; vb32 = vb[3:0]; vld32 = 1'b1; lst32 = (b == beats - 1);
      end else begin
        d64 = w; vb64 = vb; vld64 = 1'b1; lst64 = (b == beats - 1);
      end
      guard = 0; took = 1'b0;
      while (!took) begin
        #1;
        took = (dw == 32) ? rdy32 : rdy64;
        @(posedge clk);
        if (!took) begin
          guard++;
          if (guard > 200) begin
            cmp++; fails++;
            $display("[TB] FAIL send_timeout: beat %0d not accepted, rdy=0 required 1", b);
            timed_out = 1'b1;
            break;
          end
          @(negedge clk);
        end
      end
    end
    #1;
    vld32 = 1'b0; lst32 = 1'b0; vld64 = 1'b0; lst64 = 1'b0;
  endtask

  task automatic run_message(input string name, input int dw, input int n, input bit abc);
    int    nexp, got, guard;
    word_t e, o;
    load_msg(n, abc);
    exp_q.delete();
    build_exp(dw);
    nexp = exp_q.size();
    obs32.delete(); obs64.delete(); run_words.delete();
    send_msg(dw, -1);
    guard = 0;
    while (((dw == 32) ? obs32.size() : obs64.size()) < nexp && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    got = (dw == 32) ? obs32.size() : obs64.size();
    cmp++;
    if (got != nexp) begin
      fails++;
      $display("[TB] FAIL %s word_count: got %0d required %0d", name, got, nexp);
    end
    for (int i = 0; i < got && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (dw == 32) ? obs32[i] : obs64[i];
      run_words.push_back(o);
      cmp++;
      if (o !== e) begin
        fails++;
        $display("[TB] FAIL %s word%0d: got d=%h lst=%b blk=%b required d=%h lst=%b blk=%b",
                 name, i, o.d, o.lst, o.blk, e.d, e.lst, e.blk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1;
    vld32 = 1'b0; lst32 = 1'b0; d32 = '0; vb32 = '0;
    vld64 = 1'b0; lst64 = 1'b0; d64 = '0; vb64 = '0;
    repeat (3) @(negedge clk);
    #1;
    cmp++;
    if ({od32, ovld32, olst32, oblk32, rdy32} !== 36'd0) begin
      fails++;
      $display("[TB] FAIL reset32: got %h/%b%b%b rdy=%b required all 0", od32, ovld32, olst32, oblk32, rdy32);
    end
    cmp++;
    if ({od64, ovld64, olst64, oblk64, rdy64} !== 68'd0) begin
      fails++;
      $display("[TB] FAIL reset64: got %h/%b%b%b rdy=%b required all 0", od64, ovld64, olst64, oblk64, rdy64);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_byte_ins();
    logic [31:0] ones, expv;
    ones = 32'hFFFF_FFFF;
    ins_d = 32'hA1B2_C3D4;
    for (int k = 0; k <= 4; k++) begin
      ins_k = 3'(k);
      #1;
      if (k == 4) expv = ins_d;
      else expv = (ins_d & ~(ones >> (8 * k))) | (32'h80 << (8 * (3 - k)));
      cmp++;
      if (ins_q !== expv) begin
        fails++;
        $display("[TB] FAIL byte_ins k=%0d: got %h required %h", k, ins_q, expv);
      end
    end
  endtask

  task automatic test_abc32();
    run_message("abc32", 32, 0, 1'b1);
    if (run_words.size() == 16) begin
      cmp++;
      if (run_words[0].d !== 64'h6162_6380) begin
        fails++; $display("[TB] FAIL abc32_w0: got %h required 61626380", run_words[0].d);
      end
      cmp++;
      if ({run_words[15].d, run_words[15].lst, run_words[15].blk} !== {64'h18, 2'b11}) begin
        fails++; $display("[TB] FAIL abc32_w15: got %h lst=%b blk=%b required 18 1 1",
                          run_words[15].d, run_words[15].lst, run_words[15].blk);
      end
    end
  endtask

  task automatic test_empty32();
    run_message("empty32", 32, 0, 1'b0);
    if (run_words.size() == 16) begin
      cmp++;
      if (run_words[0].d !== 64'h8000_0000) begin
        fails++; $display("[TB] FAIL empty32_w0: got %h required 80000000", run_words[0].d);
      end
      cmp++;
      if ({run_words[15].d, run_words[15].lst} !== {64'h0, 1'b1}) begin
        fails++; $display("[TB] FAIL empty32_w15: got %h lst=%b required 0 1", run_words[15].d, run_words[15].lst);
      end
    end
  endtask

  task automatic test_boundary_55_56();
    run_message("len55", 32, 55, 1'b0);
    if (run_words.size() == 16) begin
      cmp++;
      if (run_words[13].d[7:0] !== 8'h80 || run_words[15].d !== 64'h1B8) begin
        fails++; $display("[TB] FAIL len55: got w13=%h w15=%h required w13 low 80, w15=1b8",
                          run_words[13].d, run_words[15].d);
      end
    end
    run_message("len56", 32, 56, 1'b0);
    if (run_words.size() == 32) begin
      cmp++;
      if (run_words[14].d !== 64'h8000_0000 || run_words[15].blk !== 1'b1 || run_words[15].lst !== 1'b0) begin
        fails++; $display("[TB] FAIL len56_first_block: got w14=%h blk=%b lst=%b required 80000000 1 0",
                          run_words[14].d, run_words[15].blk, run_words[15].lst);
      end
      cmp++;
      if (run_words[31].d !== 64'h1C0 || run_words[31].lst !== 1'b1) begin
        fails++; $display("[TB] FAIL len56_w31: got %h lst=%b required 1c0 1", run_words[31].d, run_words[31].lst);
      end
    end
  endtask

  task automatic test_abc64();
    run_message("abc64", 64, 0, 1'b1);
    if (run_words.size() == 8) begin
      cmp++;
      if (run_words[0].d !== 64'h6162_6380_0000_0000) begin
        fails++; $display("[TB] FAIL abc64_w0: got %h required 6162638000000000", run_words[0].d);
      end
      cmp++;
      if (run_words[7].d !== 64'h18 || run_words[7].lst !== 1'b1) begin
        fails++; $display("[TB] FAIL abc64_w7: got %h lst=%b required 18 1", run_words[7].d, run_words[7].lst);
      end
    end
  endtask

  task automatic test_random_lengths();
    for (int it = 0; it < 6; it++)
      run_message((it % 2) ? "rand64" : "rand32", (it % 2) ? 64 : 32, $urandom_range(0, 130), 1'b0);
  endtask

  task automatic stall_check(input string name);
    logic [31:0] sd;
    logic        sv, sl, sb;
    ena = 1'b0;
    #1;
    sd = od32; sv = ovld32; sl = olst32; sb = oblk32;
    repeat (3) begin
      @(posedge clk);
      #1;
      cmp++;
      if ({rdy32, od32, ovld32, olst32, oblk32} !== {1'b0, sd, sv, sl, sb}) begin
        fails++;
        $display("[TB] FAIL stall_%s: got rdy=%b d=%h vld=%b lst=%b blk=%b required rdy=0 d=%h vld=%b lst=%b blk=%b",
                 name, rdy32, od32, ovld32, olst32, oblk32, sd, sv, sl, sb);
      end
    end
    @(negedge clk);
    ena = 1'b1;
  endtask

  task automatic test_backpressure();
    fork
      run_message("stall56", 32, 56, 1'b0);
      begin
        repeat (4) @(negedge clk);
        stall_check("data");
        repeat (20) @(negedge clk);
        stall_check("pad");
      end
    join
  endtask

  task automatic test_reset_mid();
    load_msg(40, 1'b0);
    send_msg(32, 3);
    rst = 1'b1;
    #1;
    cmp++;
    if ({od32, ovld32, olst32, oblk32, rdy32} !== 36'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid: got %h/%b%b%b rdy=%b required all 0", od32, ovld32, olst32, oblk32, rdy32);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_message("abc_after_reset", 32, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_byte_ins();
    test_abc32();
    test_empty32();
    test_boundary_55_56();
    test_abc64();
    test_random_lengths();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule
